// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle RV32I controller and its datapath muxes.
//   state_t   - controller states
//   OP_*      - supported major opcodes (instr[6:0])
//   ALU_*     - ALUControl encodings
//   IMM_*     - ImmSrc encodings
//   SRCA_*    - ALUSrcA encodings
//   SRCB_*    - ALUSrcB encodings
//   RES_*     - ResultSrc encodings
//   alu_op_t  - ALU operation class handed from the FSM to the ALU decoder
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRWB
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM's ALU operation class plus funct3/funct7 to ALUControl.
//   op          in  7  opcode (selects whether funct7 distinguishes add/sub)
//   funct3      in  3  instr[14:12]
//   funct7      in  1  instr[30]
//   alu_op      in     operation class from the FSM
//   alu_control out 3  ALUControl encoding
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  alu_op_t    alu_op,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        if (alu_op == ALUOP_SUB)
            alu_control = ALU_SUB;
        else if (alu_op == ALUOP_FUNCT)
            case (funct3)
                // only register-register ops use funct7 to select subtract
                3'b000:  alu_control = (op == OP_R && funct7) ? ALU_SUB : ALU_ADD;
                3'b111:  alu_control = ALU_AND;
                3'b110:  alu_control = ALU_OR;
                3'b100:  alu_control = ALU_XOR;
                3'b010:  alu_control = ALU_SLT;
                3'b001:  alu_control = ALU_SLL;
                3'b101:  alu_control = ALU_SRL;
                default: alu_control = ALU_ADD;
            endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I main controller with retired-instruction counter.
//   clk, rst (async, active-low)
//   op, funct3, funct7, Zero, mem_ready        - decode fields, ALU flag, memory handshake
//   mem_req, MemWrite, AdrSrc                  - memory access control
//   IRWrite, PCWrite, RegWrite                 - architectural write enables
//   ALUSrcA, ALUSrcB, ALUControl, ImmSrc, ResultSrc - datapath selects
//   retire, illegal                            - per-instruction event pulses
//   instret                                    - retired-instruction count (wraps)
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [2:0]       ImmSrc,
    output logic [1:0]       ResultSrc,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t  state, next_state;
    alu_op_t alu_op;
    logic    req, we, irw, pcw, rw, ret, ill;

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_op      (alu_op),
        .alu_control (ALUControl)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= S_FETCH;
        else
            state <= next_state;

    always_comb begin
        next_state = state;
        req        = 1'b0;
        we         = 1'b0;
        irw        = 1'b0;
        pcw        = 1'b0;
        rw         = 1'b0;
        ret        = 1'b0;
        ill        = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        ResultSrc  = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                req        = 1'b1;
                ALUSrcB    = SRCB_4;
                ResultSrc  = RES_ALU;
                irw        = mem_ready;
                pcw        = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut while the opcode is decoded
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECR;
                    OP_I:              next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    default: begin
                        ill        = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
                next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req        = 1'b1;
                AdrSrc     = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = RES_MEM;
                rw         = 1'b1;
                ret        = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                req        = 1'b1;
                AdrSrc     = 1'b1;
                we         = 1'b1;
                ret        = mem_ready;
                next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = SRCA_ZERO;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                rw         = 1'b1;
                ret        = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                // funct3[0] turns beq into bne
                ALUSrcA    = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                pcw        = Zero ^ funct3[0];
                ret        = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_4;
                pcw        = 1'b1;
                next_state = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALU;
                pcw        = 1'b1;
                next_state = S_JALRWB;
            end
            S_JALRWB: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_4;
                ResultSrc  = RES_ALU;
                rw         = 1'b1;
                ret        = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // reset gates strobes combinationally so nothing is written while rst is low
    assign mem_req  = rst & req;
    assign MemWrite = rst & we;
    assign IRWrite  = rst & irw;
    assign PCWrite  = rst & pcw;
    assign RegWrite = rst & rw;
    assign retire   = rst & ret;
    assign illegal  = rst & ill;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            instret <= '0;
        else if (retire)
            instret <= instret + CNT_W'(1);

endmodule
